// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder (g0=133o, g1=171o), serial A-then-B output.
// Latency: zero; coded bit is combinational from the current input and state.
// Backpressure: none; consumes one input bit every two clocks, emits one bit per clock.
module conv_encoder (
    input  logic clk_i,
    input  logic rst_i,
    input  logic data_i,
    output logic coded_o
);

    // Phase encoding: A (g0) is emitted first, B (g1) second.
    localparam logic [0:0] PH_A = 1'b0;
    localparam logic [0:0] PH_B = 1'b1;

    // Generator polynomials; bit 6 is the current input, bit 0 the oldest delay.
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    // shift_q[1] holds the most recent past bit, shift_q[6] the oldest.
    logic [6:1] shift_q;
    logic [6:1] shift_d;
    logic [0:0] phase_q;
    logic [0:0] phase_d;

    // Window of the current bit followed by the delay line, aligned to the polynomials.
    logic [6:0] window;
    logic       code_a;
    logic       code_b;

    // Coded bits and output mux; the output path has no register stage.
    always_comb begin
        window  = {data_i, shift_q[1], shift_q[2], shift_q[3],
                   shift_q[4], shift_q[5], shift_q[6]};
        code_a  = ^(window & G0);
        code_b  = ^(window & G1);
        coded_o = (phase_q == PH_A) ? code_a : code_b;
    end

    // Next state: toggle phase every clock; the input bit enters the delay line
    // only at the end of its B cycle, so both coded bits see the same history.
    always_comb begin
        phase_d = phase_q;
        shift_d = shift_q;
        case (phase_q)
            PH_A: begin
                phase_d = PH_B;
            end
            PH_B: begin
                phase_d = PH_A;
                shift_d = {shift_q[5:1], data_i};
            end
            default: begin
                phase_d = PH_A;
            end
        endcase
    end

    // State registers; reset clears immediately and abandons any half-emitted pair.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            phase_q <= PH_A;
        end else begin
            shift_q <= shift_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: queue-based software K=7 encoder as reference,
// literal sequences for constant-ones, all-zeros and impulse, async reset mid-pair,
// reset held across edges, and a random 200-bit stream.
module tb_conv_encoder;

    logic clk_i;
    logic rst_i;
    logic data_i;
    logic coded_o;

    conv_encoder dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .coded_o (coded_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state: past input bits, most recent at index 0.
    bit   past[$];
    bit   ph;          // 0: next output is A, 1: next output is B
    logic exp_bit;
    logic chk_en;
    logic [63:0] cap;  // sampled DUT outputs, newest in bit 0
    logic [63:0] mcap; // model outputs, newest in bit 0

    // Parity of the generator taps applied to the current bit and its history.
    function automatic logic gen_bit(input logic d, input logic [6:0] poly);
        logic r;
        r = poly[6] & d;
        for (int k = 1; k <= 6; k++) begin
            if (poly[6-k] && (k <= past.size()))
                r = r ^ past[k-1];
        end
        return r;
    endfunction

    function automatic logic model_out(input logic d);
        return ph ? gen_bit(d, 7'o171) : gen_bit(d, 7'o133);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Single compare process: every mid-cycle sample against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            total++;
            if (coded_o !== exp_bit) begin
                bad++;
                $display("FAIL stream t=%0t: got %b expected %b (data=%b rst=%b)",
                         $time, coded_o, exp_bit, data_i, rst_i);
            end
            cap  <= {cap[62:0], coded_o};
            mcap <= {mcap[62:0], exp_bit};
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input logic d);
        data_i  = d;
        exp_bit = rst_i ? d : model_out(d);
        @(posedge clk_i);
        #1;
        if (!rst_i) begin
            if (ph) begin
                past.push_front(d);
                if (past.size() > 6)
                    void'(past.pop_back());
            end
            ph = ~ph;
        end
    endtask

    task automatic model_clear();
        past.delete();
        ph = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_clear();
        step(1'b0);
        step(1'b1);
        rst_i = 1'b0;
    endtask

    logic b;

    initial begin
        chk_en  = 1'b0;
        cap     = '0;
        mcap    = '0;
        rst_i   = 1'b1;
        data_i  = 1'b0;
        exp_bit = 1'b0;
        model_clear();
        #2;
        // Reset state: output is A with zero state, i.e. equals the input.
        check("reset_out_in0", {63'd0, coded_o}, 64'd0);
        data_i = 1'b1;
        #1;
        check("reset_out_in1", {63'd0, coded_o}, 64'd1);
        @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        do_reset();

        // Constant ones.
        for (int i = 0; i < 16; i++) step(1'b1);
        check("ones16_dut",   cap[15:0],  64'b1110011010001111);
        check("ones16_model", mcap[15:0], 64'b1110011010001111);
        for (int i = 0; i < 8; i++) step(1'b1);
        check("ones_tail", cap[7:0], 64'hFF);

        // All zeros.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0);
        check("zeros20", cap[19:0], 64'd0);

        // Impulse.
        do_reset();
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 16; i++) step(1'b0);
        check("impulse_dut",   cap[17:0],  64'b110111110010110000);
        check("impulse_model", mcap[17:0], 64'b110111110010110000);

        // Async reset mid-pair: 9 clocks of ones leaves the encoder in a B cycle.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1);
        check("pre_reset_B", {63'd0, coded_o}, {63'd0, gen_bit(1'b1, 7'o171)});
        #2;
        rst_i = 1'b1;
        model_clear();
        #1;
        check("async_rst_one", {63'd0, coded_o}, 64'd1);
        data_i = 1'b0;
        #1;
        check("async_rst_zero", {63'd0, coded_o}, 64'd0);
        data_i  = 1'b1;
        exp_bit = 1'b1;
        @(posedge clk_i);
        #1;
        // Reset held across edges: output tracks input, phase never advances.
        for (int i = 0; i < 6; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b);
        end
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1);
        check("restart_ones16", cap[15:0], 64'b1110011010001111);

        // Random 200-bit stream, each bit held for its A/B pair.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b);
            step(b);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-7 convolutional encoder for the 802.11a transmit chain, placed between the scrambler and the puncturer/interleaver. It takes one data bit per two clocks and emits the two coded bits serially, one per clock: the A output (generator g0 = 133 octal) first, then the B output (g1 = 171 octal). Output is a single serial bit stream at the clock rate.

## Interface
- No parameters. Generators are fixed: g0 = 133 octal, g1 = 171 octal.
- One clock; reset is asynchronous and active-high.
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Input  input  1  uncoded data bit. Must be held stable for both cycles of its A/B pair.
- Output  output  1  coded serial bit: A during phase 0, B during phase 1.

## Operation
- **State:**
  - 6-bit shift register `s[1..6]`, where `s[1]` is the most recent past bit.
  - 1-bit `phase`: 0 selects A, 1 selects B.
- **Current tap:** `d0` = `Input`.
- **Coded bits (combinational):**
  - A = `d0 ^ s[2] ^ s[3] ^ s[5] ^ s[6]` (taps 1011011).
  - B = `d0 ^ s[1] ^ s[2] ^ s[3] ^ s[6]` (taps 1111001).
- **Output mux:** `Output` = (`phase` == 0) ? A : B. This path is purely combinational from `phase`, `s` and `Input`, with no register stage.
- **Rising edge, `phase` == 0:** `phase` goes to 1; `s` is unchanged.
- **Rising edge, `phase` == 1:** `phase` goes to 0; `s` shifts so that `s[1]` takes `Input`, `s[k+1]` takes `s[k]`, and `s[6]` is discarded.
- **Reset asserted (any time, including mid-pair):**
  - `s` clears to 0 and `phase` clears to 0 immediately, without waiting for a clock edge.
  - A partially emitted pair is abandoned.
- **Reset value of `Output`:** A computed with `s` = 0, i.e. `Output` equals `Input`.
- **Encoding restart:** encoding resumes from the all-zero state with the A bit of the bit presented after reset.
- **Steady stream:** no stall or valid signalling. The encoder consumes one input bit every 2 clocks.

## Timing
- **Latency:** zero. A for a bit appears combinationally in the cycle the bit is presented.
- **Pair timing:**
  - B follows A exactly one clock later.
  - The bit enters `s` on the rising edge that ends its B cycle.
- **Reset release:** the first cycle after release (before any rising edge) is phase 0 and outputs A of the first bit.
- **Sampling:** benches sample `Output` mid-cycle, away from clock edges.
- **Input changes:** `Input` may change only on the edge that ends a B cycle. Changing it mid-pair corrupts B; this is not required to be detected.
- **Throughput:** 1 input bit per 2 clocks, 1 output bit per clock.

## Test plan
- **Constant ones:**
  - Stimulus: assert Reset, release it, then hold `Input` = 1 for 16 clocks.
  - Required `Output` sequence: 1110011010001111, i.e. pairs 11 10 01 10 10 00 11 11.
  - Continuing past 16 clocks, `Output` stays 1 every cycle.
- **All zeros:** `Input` = 0 after reset → `Output` = 0 every cycle.
- **Impulse:**
  - Stimulus: single 1 followed by zeros.
  - Required pairs (A,B) for 7 pairs: 11, 01, 11, 11, 00, 10, 11; then 00 thereafter.
- **Async reset mid-stream:**
  - Stimulus: run constant ones for 9 clocks, i.e. mid-pair.
  - Assert Reset between edges → `Output` immediately equals `Input` (1) and `phase` is 0.
  - After release, the sequence restarts at 1110….
- **Reference model:** random 200-bit stream compared against a software K=7 encoder (133/171, A first) → bit-exact match on all 400 output bits.
- **Reset held across edges:** with Reset high for several clocks, `Output` tracks `Input` combinationally and `phase` never advances.
